// File: rtl/posi_ref_fetch.sv
`default_nettype none
//==============================================================================
// Module   : posi_ref_fetch
// Brief    : Post-intra reference-pixel fetch. Reads the row / column /
//            frame-row neighbour RAMs and streams one block's intra reference
//            groups (bottom-left -> corner -> top-right), one beat per cycle.
//            A read issued in cycle t gives a registered beat in cycle t+2.
// Options  : POSI_REF_PAD_EN - unavailable beats carry padded pixels instead
//            of zero data.
// Revision : 1.0 - initial release
//==============================================================================
module posi_ref_fetch #(
    parameter int PIXEL_WIDTH = 8,
    parameter int PIC_X_WIDTH = 8,
    parameter int PIC_Y_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       start_i,
    output logic                       done_o,
    input  logic [1:0]                 blk_siz_i,
    input  logic [3:0]                 blk_4x4_x_i,
    input  logic [3:0]                 blk_4x4_y_i,
    input  logic [PIC_X_WIDTH-1:0]     ctu_x_cur_i,
    input  logic [PIC_X_WIDTH-1:0]     ctu_x_max_i,
    input  logic [PIC_Y_WIDTH-1:0]     ctu_y_cur_i,
    input  logic                       avail_bl_i,
    input  logic                       avail_ar_i,
    output logic                       row_rd_ena_o,
    output logic [7:0]                 row_rd_adr_o,
    input  logic [PIXEL_WIDTH*4-1:0]   row_rd_dat_i,
    output logic                       col_rd_ena_o,
    output logic [7:0]                 col_rd_adr_o,
    input  logic [PIXEL_WIDTH*4-1:0]   col_rd_dat_i,
    output logic                       fra_rd_ena_o,
    output logic [PIC_X_WIDTH+3:0]     fra_rd_adr_o,
    input  logic [PIXEL_WIDTH*4-1:0]   fra_rd_dat_i,
    output logic                       ref_val_o,
    output logic [1:0]                 ref_side_o,
    output logic [3:0]                 ref_idx_o,
    output logic                       ref_avl_o,
    output logic [PIXEL_WIDTH*4-1:0]   ref_dat_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LEFT   = 2'd1,
        S_CORNER = 2'd2,
        S_TOP    = 2'd3
    } state_t;

    localparam logic [1:0] SIDE_LEFT   = 2'd0;
    localparam logic [1:0] SIDE_TOP    = 2'd1;
    localparam logic [1:0] SIDE_CORNER = 2'd2;

    localparam logic [1:0] SRC_NONE = 2'd0;
    localparam logic [1:0] SRC_COL  = 2'd1;
    localparam logic [1:0] SRC_ROW  = 2'd2;
    localparam logic [1:0] SRC_FRA  = 2'd3;

    state_t state, state_nxt;
    logic [3:0] cnt, cnt_nxt;

    // block parameters captured when a fetch is accepted
    logic [1:0]             siz;
    logic [3:0]             bx, by;
    logic [PIC_X_WIDTH-1:0] cx, cxmax;
    logic [PIC_Y_WIDTH-1:0] cy;
    logic                   abl, aar;

    logic [3:0] n4, last_idx, start_n4, start_last;
    logic [3:0] bxm1, bym1;
    logic [4:0] ysum, xsum;
    logic       left_base, top_base;

    // issue stage (combinational) and read-latency stage (registered)
    logic       beat_val, beat_avl;
    logic [1:0] beat_side, beat_src;
    logic [3:0] beat_idx;
    logic       beat_last;
    logic       p1_val, p1_avl, p1_last;
    logic [1:0] p1_side, p1_src;
    logic [3:0] p1_idx;
    logic       last_q;

    logic [PIXEL_WIDTH*4-1:0] src_dat, sel_dat, beat_dat;

`ifdef POSI_REF_PAD_EN
    localparam logic [PIXEL_WIDTH-1:0] PAD_MID = {1'b1, {(PIXEL_WIDTH-1){1'b0}}};
    logic [PIXEL_WIDTH-1:0] pad_pix, pad_use;
    logic                   pad_have, p1_first;
`endif

    assign n4         = 4'd1 << siz;
    assign last_idx   = {n4[2:0], 1'b0} - 4'd1;
    assign start_n4   = 4'd1 << blk_siz_i;
    assign start_last = {start_n4[2:0], 1'b0} - 4'd1;
    assign bxm1       = bx - 4'd1;
    assign bym1       = by - 4'd1;
    assign ysum       = {1'b0, by} + {1'b0, cnt};
    assign xsum       = {1'b0, bx} + {1'b0, cnt};
    assign left_base  = !((cx == '0) && (bx == 4'd0));
    assign top_base   = !((cy == '0) && (by == 4'd0));

    // state and group counter
    always_ff @(posedge clk) begin
        if (rstn) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // capture block parameters on an accepted start
    always_ff @(posedge clk) begin
        if (rstn) begin
            siz <= '0; bx <= '0; by <= '0; cx <= '0; cxmax <= '0; cy <= '0;
            abl <= 1'b0; aar <= 1'b0;
        end else if (state == S_IDLE && start_i) begin
            siz   <= blk_siz_i;
            bx    <= blk_4x4_x_i;
            by    <= blk_4x4_y_i;
            cx    <= ctu_x_cur_i;
            cxmax <= ctu_x_max_i;
            cy    <= ctu_y_cur_i;
            abl   <= avail_bl_i;
            aar   <= avail_ar_i;
        end
    end

    // next state, RAM read requests and per-beat availability
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        row_rd_ena_o = 1'b0;
        row_rd_adr_o = '0;
        col_rd_ena_o = 1'b0;
        col_rd_adr_o = '0;
        fra_rd_ena_o = 1'b0;
        fra_rd_adr_o = '0;
        beat_val     = 1'b0;
        beat_avl     = 1'b0;
        beat_side    = SIDE_LEFT;
        beat_src     = SRC_NONE;
        beat_idx     = '0;
        beat_last    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_i) begin
                    state_nxt = S_LEFT;
                    cnt_nxt   = start_last;
                end
            end
            S_LEFT: begin
                beat_val     = 1'b1;
                beat_idx     = cnt;
                beat_avl     = left_base && !ysum[4] && ((cnt < n4) || abl);
                col_rd_adr_o = {bxm1, ysum[3:0]};
                col_rd_ena_o = beat_avl;
                beat_src     = beat_avl ? SRC_COL : SRC_NONE;
                if (cnt == 4'd0) state_nxt = S_CORNER;
                else             cnt_nxt   = cnt - 4'd1;
            end
            S_CORNER: begin
                beat_val  = 1'b1;
                beat_side = SIDE_CORNER;
                beat_avl  = left_base && top_base;
                if (by != 4'd0) begin
                    row_rd_adr_o = {bym1, bxm1};
                    row_rd_ena_o = beat_avl;
                    beat_src     = beat_avl ? SRC_ROW : SRC_NONE;
                end else begin
                    // block origin on column 0 takes the previous CTU's last group
                    fra_rd_adr_o = (bx == 4'd0) ? {cx - PIC_X_WIDTH'(1), 4'hF} : {cx, bxm1};
                    fra_rd_ena_o = beat_avl;
                    beat_src     = beat_avl ? SRC_FRA : SRC_NONE;
                end
                state_nxt = S_TOP;
                cnt_nxt   = '0;
            end
            S_TOP: begin
                beat_val  = 1'b1;
                beat_side = SIDE_TOP;
                beat_idx  = cnt;
                beat_last = (cnt == last_idx);
                beat_avl  = top_base && ((cnt < n4) || aar) &&
                            (!xsum[4] || ((by == 4'd0) && (cx != cxmax)));
                if (by != 4'd0) begin
                    row_rd_adr_o = {bym1, xsum[3:0]};
                    row_rd_ena_o = beat_avl;
                    beat_src     = beat_avl ? SRC_ROW : SRC_NONE;
                end else begin
                    fra_rd_adr_o = xsum[4] ? {cx + PIC_X_WIDTH'(1), xsum[3:0]} : {cx, xsum[3:0]};
                    fra_rd_ena_o = beat_avl;
                    beat_src     = beat_avl ? SRC_FRA : SRC_NONE;
                end
                if (beat_last) state_nxt = S_IDLE;
                else           cnt_nxt   = cnt + 4'd1;
            end
            default: state_nxt = S_IDLE;
        endcase
        // keep the RAMs quiet while reset is held
        if (rstn) begin
            row_rd_ena_o = 1'b0;
            col_rd_ena_o = 1'b0;
            fra_rd_ena_o = 1'b0;
        end
    end

    // carry beat metadata alongside the one-cycle RAM read
    always_ff @(posedge clk) begin
        if (rstn) begin
            p1_val <= 1'b0; p1_avl <= 1'b0; p1_last <= 1'b0;
            p1_side <= '0; p1_src <= '0; p1_idx <= '0;
        end else begin
            p1_val  <= beat_val;
            p1_avl  <= beat_avl;
            p1_last <= beat_last;
            p1_side <= beat_side;
            p1_src  <= beat_src;
            p1_idx  <= beat_idx;
        end
    end

    // select RAM data, replicate the corner pixel, substitute unavailable data
    always_comb begin
        case (p1_src)
            SRC_COL: src_dat = col_rd_dat_i;
            SRC_ROW: src_dat = row_rd_dat_i;
            SRC_FRA: src_dat = fra_rd_dat_i;
            default: src_dat = '0;
        endcase
        sel_dat = (p1_side == SIDE_CORNER) ? {4{src_dat[PIXEL_WIDTH-1:0]}} : src_dat;
`ifdef POSI_REF_PAD_EN
        // the first beat of a block never inherits a pixel from the previous block
        p1_first = (p1_side == SIDE_LEFT) && (p1_idx == last_idx);
        pad_use  = (p1_first || !pad_have) ? PAD_MID : pad_pix;
        beat_dat = p1_avl ? sel_dat : {4{pad_use}};
`else
        beat_dat = p1_avl ? sel_dat : '0;
`endif
    end

    // registered beat outputs and end-of-block pulse
    always_ff @(posedge clk) begin
        if (rstn) begin
            ref_val_o  <= 1'b0;
            ref_side_o <= '0;
            ref_idx_o  <= '0;
            ref_avl_o  <= 1'b0;
            ref_dat_o  <= '0;
            last_q     <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            ref_val_o  <= p1_val;
            ref_side_o <= p1_side;
            ref_idx_o  <= p1_idx;
            ref_avl_o  <= p1_avl;
            ref_dat_o  <= beat_dat;
            last_q     <= p1_val && p1_last;
            done_o     <= last_q;
        end
    end

`ifdef POSI_REF_PAD_EN
    // remember lane 3 of the most recent available beat for padding
    always_ff @(posedge clk) begin
        if (rstn) begin
            pad_pix  <= '0;
            pad_have <= 1'b0;
        end else if (p1_val) begin
            if (p1_avl) begin
                pad_pix  <= beat_dat[PIXEL_WIDTH-1:0];
                pad_have <= 1'b1;
            end else if (p1_first) begin
                pad_have <= 1'b0;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_posi_ref_fetch.sv
`default_nettype none
//==============================================================================
// Module   : tb_posi_ref_fetch
// Brief    : Directed self-checking bench for posi_ref_fetch with behavioural
//            row / col / fra RAMs holding address-encoded data.
// Revision : 1.0 - initial release
//==============================================================================
module tb_posi_ref_fetch;

    logic        clk = 1'b0;
    logic        rstn, start_i, done_o;
    logic [1:0]  blk_siz_i;
    logic [3:0]  blk_4x4_x_i, blk_4x4_y_i;
    logic [7:0]  ctu_x_cur_i, ctu_x_max_i, ctu_y_cur_i;
    logic        avail_bl_i, avail_ar_i;
    logic        row_rd_ena_o, col_rd_ena_o, fra_rd_ena_o;
    logic [7:0]  row_rd_adr_o, col_rd_adr_o;
    logic [11:0] fra_rd_adr_o;
    logic [31:0] row_rd_dat_i, col_rd_dat_i, fra_rd_dat_i;
    logic        ref_val_o, ref_avl_o;
    logic [1:0]  ref_side_o;
    logic [3:0]  ref_idx_o;
    logic [31:0] ref_dat_o;

    always #5 clk = ~clk;

    posi_ref_fetch #(.PIXEL_WIDTH(8), .PIC_X_WIDTH(8), .PIC_Y_WIDTH(8)) dut (
        .clk(clk), .rstn(rstn), .start_i(start_i), .done_o(done_o),
        .blk_siz_i(blk_siz_i), .blk_4x4_x_i(blk_4x4_x_i), .blk_4x4_y_i(blk_4x4_y_i),
        .ctu_x_cur_i(ctu_x_cur_i), .ctu_x_max_i(ctu_x_max_i), .ctu_y_cur_i(ctu_y_cur_i),
        .avail_bl_i(avail_bl_i), .avail_ar_i(avail_ar_i),
        .row_rd_ena_o(row_rd_ena_o), .row_rd_adr_o(row_rd_adr_o), .row_rd_dat_i(row_rd_dat_i),
        .col_rd_ena_o(col_rd_ena_o), .col_rd_adr_o(col_rd_adr_o), .col_rd_dat_i(col_rd_dat_i),
        .fra_rd_ena_o(fra_rd_ena_o), .fra_rd_adr_o(fra_rd_adr_o), .fra_rd_dat_i(fra_rd_dat_i),
        .ref_val_o(ref_val_o), .ref_side_o(ref_side_o), .ref_idx_o(ref_idx_o),
        .ref_avl_o(ref_avl_o), .ref_dat_o(ref_dat_o)
    );

    // RAM contents: {tag, 0, adr[11:8], adr[7:0], adr[7:0]^tag}; lane 3 is the LSB byte
    function automatic logic [31:0] enc(input logic [7:0] tag, input logic [11:0] adr);
        return {tag, 4'h0, adr[11:8], adr[7:0], adr[7:0] ^ tag};
    endfunction

    function automatic logic [31:0] rep(input logic [31:0] d);
        return {4{d[7:0]}};
    endfunction

    function automatic logic [31:0] pad(input logic [7:0] p);
`ifdef POSI_REF_PAD_EN
        return {4{p}};
`else
        return (p == 8'h00) ? 32'h0 : 32'h0;
`endif
    endfunction

    // one-cycle-latency read ports
    always @(posedge clk) begin
        if (row_rd_ena_o) row_rd_dat_i <= enc(8'hA0, {4'h0, row_rd_adr_o});
        if (col_rd_ena_o) col_rd_dat_i <= enc(8'hC0, {4'h0, col_rd_adr_o});
        if (fra_rd_ena_o) fra_rd_dat_i <= enc(8'hF0, fra_rd_adr_o);
    end

    typedef struct packed {
        logic [1:0]  side;
        logic [3:0]  idx;
        logic        avl;
        logic [31:0] dat;
    } beat_t;

    beat_t got_q[$];
    beat_t exp_q[$];
    int    got_cyc[$];
    int    done_cyc[$];
    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // collect beats and done pulses away from the active edge
    always @(negedge clk) begin
        beat_t b;
        if (ref_val_o) begin
            b.side = ref_side_o; b.idx = ref_idx_o; b.avl = ref_avl_o; b.dat = ref_dat_o;
            got_q.push_back(b);
            got_cyc.push_back(cyc);
        end
        if (done_o) done_cyc.push_back(cyc);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [1:0] s, input logic [3:0] i, input logic a, input logic [31:0] d);
        beat_t b;
        b.side = s; b.idx = i; b.avl = a; b.dat = d;
        exp_q.push_back(b);
    endtask

    task automatic clear_all();
        got_q.delete(); got_cyc.delete(); done_cyc.delete(); exp_q.delete();
    endtask

    task automatic pulse_start(input logic [1:0] siz, input logic [3:0] bx, input logic [3:0] by,
                               input logic [7:0] cx, input logic [7:0] cxm, input logic [7:0] cy,
                               input logic bl, input logic ar, output int scyc);
        blk_siz_i = siz; blk_4x4_x_i = bx; blk_4x4_y_i = by;
        ctu_x_cur_i = cx; ctu_x_max_i = cxm; ctu_y_cur_i = cy;
        avail_bl_i = bl; avail_ar_i = ar;
        start_i = 1'b1;
        scyc = cyc;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (done_cyc.size() < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, " done within budget"}, done_cyc.size() >= target, 1);
        repeat (4) @(negedge clk);
    endtask

    task automatic compare_beats(input string name);
        check({name, " beat count"}, got_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
            check($sformatf("%s beat%0d", name, k), got_q[k], exp_q[k]);
    endtask

    task automatic check_timing(input string name, input int scyc);
        if (got_cyc.size() > 0) begin
            check({name, " first beat cycle"}, got_cyc[0], scyc + 3);
            check({name, " last beat cycle"}, got_cyc[got_cyc.size()-1], scyc + 2 + exp_q.size());
        end
        check({name, " done count"}, done_cyc.size(), 1);
        if (done_cyc.size() > 0)
            check({name, " done cycle"}, done_cyc[0], scyc + 3 + exp_q.size());
    endtask

    // 4x4 at (5,5), ctu (2,1), everything available
    task automatic exp_t1();
        push(2'd0, 4'd1, 1'b1, enc(8'hC0, 12'h046));
        push(2'd0, 4'd0, 1'b1, enc(8'hC0, 12'h045));
        push(2'd2, 4'd0, 1'b1, rep(enc(8'hA0, 12'h044)));
        push(2'd1, 4'd0, 1'b1, enc(8'hA0, 12'h045));
        push(2'd1, 4'd1, 1'b1, enc(8'hA0, 12'h046));
    endtask

    // 8x8 at (0,0) of CTU (0,0): nothing available
    task automatic exp_t2();
        for (int i = 3; i >= 0; i--) push(2'd0, 4'(i), 1'b0, pad(8'h80));
        push(2'd2, 4'd0, 1'b0, pad(8'h80));
        for (int j = 0; j < 4; j++) push(2'd1, 4'(j), 1'b0, pad(8'h80));
    endtask

    // 16x16 at (12,0), last CTU column: upper top half off the picture edge
    task automatic exp_t3();
        for (int i = 7; i >= 0; i--) push(2'd0, 4'(i), 1'b1, enc(8'hC0, {8'h0B, 4'(i)}));
        push(2'd2, 4'd0, 1'b1, 32'hCBCBCBCB);
        for (int j = 0; j < 4; j++) push(2'd1, 4'(j), 1'b1, enc(8'hF0, 12'h03C + 12'(j)));
        for (int j = 4; j < 8; j++) push(2'd1, 4'(j), 1'b0, pad(8'hCF));
    endtask

    // 4x4 at (0,8), ctu_x=1, below-left unavailable
    task automatic exp_t4();
        push(2'd0, 4'd1, 1'b0, pad(8'h80));
        push(2'd0, 4'd0, 1'b1, enc(8'hC0, 12'h0F8));
        push(2'd2, 4'd0, 1'b1, rep(enc(8'hA0, 12'h07F)));
        push(2'd1, 4'd0, 1'b1, enc(8'hA0, 12'h070));
        push(2'd1, 4'd1, 1'b1, enc(8'hA0, 12'h071));
    endtask

    // 32x32 at (0,0), ctu (2,1): corner from previous CTU, top from frame row
    task automatic exp_t5();
        for (int i = 15; i >= 0; i--) push(2'd0, 4'(i), 1'b1, enc(8'hC0, {8'h0F, 4'(i)}));
        push(2'd2, 4'd0, 1'b1, rep(enc(8'hF0, 12'h01F)));
        for (int j = 0; j < 16; j++) push(2'd1, 4'(j), 1'b1, enc(8'hF0, 12'h020 + 12'(j)));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s1, s2, n;
        rstn = 1'b1; start_i = 1'b0;
        blk_siz_i = '0; blk_4x4_x_i = '0; blk_4x4_y_i = '0;
        ctu_x_cur_i = '0; ctu_x_max_i = '0; ctu_y_cur_i = '0;
        avail_bl_i = 1'b0; avail_ar_i = 1'b0;
        repeat (3) @(negedge clk);
        check("reset ref_val", ref_val_o, 0);
        check("reset done", done_o, 0);
        check("reset ref_dat", ref_dat_o, 0);
        check("reset enables", {row_rd_ena_o, col_rd_ena_o, fra_rd_ena_o}, 0);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        clear_all();

        // T1 plus a start pulse while busy, which must be ignored
        pulse_start(2'd0, 4'd5, 4'd5, 8'd2, 8'd5, 8'd1, 1'b1, 1'b1, s1);
        @(negedge clk);
        blk_4x4_x_i = 4'd9; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        wait_done(1, 40, "t1");
        exp_t1(); compare_beats("t1"); check_timing("t1", s1); clear_all();

        pulse_start(2'd1, 4'd0, 4'd0, 8'd0, 8'd0, 8'd0, 1'b1, 1'b1, s1);
        wait_done(1, 40, "t2");
        exp_t2(); compare_beats("t2"); check_timing("t2", s1); clear_all();

        pulse_start(2'd2, 4'd12, 4'd0, 8'd3, 8'd3, 8'd1, 1'b1, 1'b1, s1);
        wait_done(1, 60, "t3");
        exp_t3(); compare_beats("t3"); check_timing("t3", s1); clear_all();

        pulse_start(2'd0, 4'd0, 4'd8, 8'd1, 8'd3, 8'd1, 1'b0, 1'b1, s1);
        wait_done(1, 40, "t4");
        exp_t4(); compare_beats("t4"); check_timing("t4", s1); clear_all();

        // T5: reset during TOP of a 32x32 block, then a clean rerun
        pulse_start(2'd3, 4'd0, 4'd0, 8'd2, 8'd3, 8'd1, 1'b1, 1'b1, s1);
        repeat (19) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        rstn = 1'b0;
        check("t5 ref_val after reset", ref_val_o, 0);
        check("t5 done after reset", done_o, 0);
        n = got_q.size();
        check("t5 beats before reset", n, 18);
        repeat (10) @(negedge clk);
        check("t5 no beats after reset", got_q.size(), n);
        check("t5 no done after reset", done_cyc.size(), 0);
        clear_all();
        pulse_start(2'd3, 4'd0, 4'd0, 8'd2, 8'd3, 8'd1, 1'b1, 1'b1, s1);
        wait_done(1, 80, "t5");
        exp_t5(); compare_beats("t5"); check_timing("t5", s1); clear_all();

        // T6: second start presented on the IDLE cycle after the first block
        pulse_start(2'd0, 4'd5, 4'd5, 8'd2, 8'd5, 8'd1, 1'b1, 1'b1, s1);
        repeat (5) @(negedge clk);
        pulse_start(2'd0, 4'd0, 4'd8, 8'd1, 8'd3, 8'd1, 1'b0, 1'b1, s2);
        wait_done(2, 60, "t6");
        exp_t1(); exp_t4(); compare_beats("t6");
        check("t6 second start cycle", s2, s1 + 6);
        check("t6 done count", done_cyc.size(), 2);
        if (got_cyc.size() >= 10 && done_cyc.size() >= 2) begin
            check("t6 first beat cycle", got_cyc[0], s1 + 3);
            check("t6 tail beat cycle", got_cyc[4], s1 + 7);
            check("t6 done0 cycle", done_cyc[0], s1 + 8);
            check("t6 second first beat", got_cyc[5], s1 + 9);
            check("t6 second last beat", got_cyc[9], s1 + 13);
            check("t6 done1 cycle", done_cyc[1], s1 + 14);
        end
        clear_all();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/posi_ref_fetch.md
# posi_ref_fetch

Reference-pixel fetch stage for post intra: reads the row, column and frame-row neighbour buffers filled by the posi transfer stage and streams the HEVC intra reference samples of one prediction block (bottom-left → top-left corner → top-right) to the intra predictor. Sits directly downstream of the transfer stage's row/col/fra RAMs and upstream of the prediction engine; one block per `start_i`.

## Interface
- `DELAY`, 2, cycles from RAM read request to registered output beat (RAM read latency 1 + output register)
- `clk`  in  1  clock
- `rstn`  in  1  reset, synchronous, active-high (`rstn`=1 resets)
- `start_i`  in  1  one-cycle request; sampled only in IDLE
- `done_o`  out  1  one-cycle pulse after last beat
- `blk_siz_i`  in  2  `SIZE_04/08/16/32` (0..3); N4 = 1,2,4,8 groups
- `blk_4x4_x_i`, `blk_4x4_y_i`  in  4 each  block origin in 4x4 units within CTU
- `ctu_x_cur_i`, `ctu_x_max_i`  in  `PIC_X_WIDTH`  current / last CTU column
- `ctu_y_cur_i`  in  `PIC_Y_WIDTH`  current CTU row
- `avail_bl_i`, `avail_ar_i`  in  1  in-CTU z-order availability of below-left / above-right halves
- `row_rd_ena_o`, `row_rd_adr_o`  out  1 / 8  {y,x}; `row_rd_dat_i` in `PIXEL_WIDTH*4`
- `col_rd_ena_o`, `col_rd_adr_o`  out  1 / 8  {x,y}; `col_rd_dat_i` in `PIXEL_WIDTH*4`
- `fra_rd_ena_o`, `fra_rd_adr_o`  out  1 / `PIC_X_WIDTH+4`  {ctu_x,x}; `fra_rd_dat_i` in `PIXEL_WIDTH*4`
- `ref_val_o`  out  1  beat valid
- `ref_side_o`  out  2  0 left, 1 top, 2 corner
- `ref_idx_o`  out  4  group index within side
- `ref_avl_o`  out  1  group sourced from a real neighbour
- `ref_dat_o`  out  `PIXEL_WIDTH*4`  pixel 0 in MSBs (left: top→bottom; top: left→right)

## Operation
- FSM IDLE → LEFT → CORNER → TOP → IDLE. IDLE→LEFT on `start_i`; block parameters latched at that edge.
- LEFT: i = 2N4−1 down to 0, one per cycle. Col read adr {(blk_x−1) mod 16, blk_y+i}; x=0 wraps to 15 (previous CTU's right column). Available iff !(ctu_x=0 && blk_x=0) && blk_y+i ≤ 15 && (i<N4 || `avail_bl_i`).
- CORNER: one cycle. y>0: row adr {blk_y−1,(blk_x−1) mod 16}; y=0: fra adr {ctu_x,blk_x−1}, or {ctu_x−1,15} when blk_x=0. Pixel = lane 3. Available iff left and top both available. Beat replicates pixel to 4 lanes.
- TOP: j = 0..2N4−1. x=blk_x+j. y>0: row adr {blk_y−1,x}, unavailable if x>15. y=0: fra adr {ctu_x,x}, or {ctu_x+1,x−16} if x>15 (unavailable when ctu_x=ctu_x_max). Also unavailable if ctu_y=0 && blk_y=0, or j≥N4 && !`avail_ar_i`.
- Unavailable groups issue no RAM read (ena low); beat still emitted with `ref_avl_o`=0.
- Exactly 4N4+1 beats per block, strictly in that order, no gaps. All address arithmetic 4-bit wrapping except explicit ±1 CTU cases.
- `start_i` outside IDLE ignored.

## Timing
- Read issued in cycle t → `ref_*` beat registered and visible in cycle t+2. First beat 3 cycles after `start_i` edge.
- `done_o` high the cycle after last beat (cycle t_last+1); FSM may accept new `start_i` the cycle it returns to IDLE (overlap of tail beats with next fetch allowed).
- Reset: all outputs 0, FSM IDLE, delay pipes cleared; reset mid-block drops in-flight beats, no `done_o`.
- RAM enables combinational from state; output data registered.

## Configuration
- `POSI_REF_PAD_EN` defined: unavailable beats carry padded data — all lanes = last available pixel emitted in stream order (lane 3 of previous available beat); if none yet, 1<<(`PIXEL_WIDTH`−1). If no sample available in whole block, all beats = 1<<(`PIXEL_WIDTH`−1). `ref_avl_o` still reports true availability.
- Undefined: unavailable beats carry all-zero data; padding left to predictor.

## Test plan
- 4x4 at (5,5), ctu (2,1), all avail, RAMs preloaded with adr-encoded data → 5 beats: col{4,6},{4,5}, corner row{4,4} lane3, row{4,5},{4,6}; `done_o` 1 cycle after 5th beat.
- 8x8 at (0,0), ctu (0,0) → 9 beats, all `ref_avl_o`=0; PAD_EN: all data 0x80808080 (8-bit); without: 0.
- 16x16 at (12,0), ctu_x=3=ctu_x_max → top j=0..3 from fra {3,12..15}, j=4..7 unavailable, padded with fra{3,15} lane 3.
- 4x4 at (0,8), ctu_x=1, `avail_bl_i`=0 → left i=1 unavailable (padded from nothing → mid-value), i=0 reads col{15,8}.
- `rstn` asserted during TOP of 32x32 → next cycle `ref_val_o`=0, no `done_o`; fresh `start_i` then produces full 33-beat stream.
- Back-to-back starts on the IDLE cycle → second stream's first beat immediately follows first stream's tail, no dropped/duplicated beat.
